// File: rtl/vga_timing_if.sv
// VGA raster timing bundle: sync, blank, pixel coordinates and frame-buffer address.
interface vga_timing_if #(
    parameter int ADDR_W = 19
);
    logic              hs;
    logic              vs;
    logic              blank_n;
    logic [ADDR_W-1:0] addr;
    logic [9:0]        x;
    logic [9:0]        y;
    logic              frame_start;

    modport master (
        output hs, vs, blank_n, addr, x, y, frame_start
    );

    modport slave (
        input hs, vs, blank_n, addr, x, y, frame_start
    );
endinterface

// File: rtl/vga_timing_core.sv
// VGA raster timing core: free-running h/v counters, sync/blank decode,
// active-pixel coordinates and a row-major frame-buffer address.
module vga_timing_core #(
    parameter int H_TOTAL = 800,
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_FRONT = 16,
    parameter int V_TOTAL = 525,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_FRONT = 10,
    parameter int ADDR_W  = 19
) (
    input  logic         iVGA_CLK,
    input  logic         iRST_n,
    vga_timing_if.master vga
);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SW   = 10'(H_SYNC);
    localparam logic [9:0] V_SW   = 10'(V_SYNC);
    localparam logic [9:0] H_ACT0 = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_ACT1 = 10'(H_TOTAL - H_FRONT);
    localparam logic [9:0] V_ACT0 = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_ACT1 = 10'(V_TOTAL - V_FRONT);

    logic [9:0]        h_cnt;
    logic [9:0]        v_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              h_act;
    logic              v_act;
    logic              blank_n;
    logic              hs;
    logic              vs;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Address clears in the HS/VS overlap so every frame starts at pixel 0.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            addr_q <= '0;
        end else if (!hs && !vs) begin
            addr_q <= '0;
        end else if (blank_n) begin
            addr_q <= addr_q + 1'b1;
        end
    end

    always_comb begin
        hs      = (h_cnt >= H_SW);
        vs      = (v_cnt >= V_SW);
        h_act   = (h_cnt >= H_ACT0) && (h_cnt < H_ACT1);
        v_act   = (v_cnt >= V_ACT0) && (v_cnt < V_ACT1);
        blank_n = h_act && v_act;
    end

    assign vga.hs          = hs;
    assign vga.vs          = vs;
    assign vga.blank_n     = blank_n;
    assign vga.addr        = addr_q;
    assign vga.x           = blank_n ? h_cnt - H_ACT0 : '0;
    assign vga.y           = blank_n ? v_cnt - V_ACT0 : '0;
    assign vga.frame_start = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: tb/tb_vga_timing_core.sv
// Bench: a shrunken raster with random async resets plus a full 640x480 instance,
// both compared every clock against an arithmetic raster model.
module tb_vga_timing_core;

    typedef struct {
        int hs, vs, bl, addr, x, y, fs;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_s = 1'b0;
    logic rst_d = 1'b0;
    int   n_s   = 0;
    int   n_d   = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    vga_timing_if #(.ADDR_W(19)) s_if ();
    vga_timing_if #(.ADDR_W(19)) d_if ();

    vga_timing_core #(
        .H_TOTAL(40), .H_SYNC(6), .H_BACK(4), .H_FRONT(3),
        .V_TOTAL(20), .V_SYNC(2), .V_BACK(3), .V_FRONT(2),
        .ADDR_W(19)
    ) u_small (
        .iVGA_CLK(clk),
        .iRST_n  (rst_s),
        .vga     (s_if.master)
    );

    vga_timing_core u_full (
        .iVGA_CLK(clk),
        .iRST_n  (rst_d),
        .vga     (d_if.master)
    );

    always @(posedge clk or negedge rst_s)
        if (!rst_s) n_s <= 0;
        else        n_s <= n_s + 1;

    always @(posedge clk or negedge rst_d)
        if (!rst_d) n_d <= 0;
        else        n_d <= n_d + 1;

    // Expected outputs n clocks after reset release, from the raster rules alone.
    function automatic exp_t model(int n, int ht, int hsw, int hb, int hf,
                                   int vt, int vsw, int vb, int vf);
        exp_t e;
        int f, r, h, v, h0, h1, v0, v1, ha, va, col;
        f  = n / (ht * vt);
        r  = n % (ht * vt);
        h  = r % ht;
        v  = r / ht;
        h0 = hsw + hb;
        h1 = ht - hf;
        v0 = vsw + vb;
        v1 = vt - vf;
        ha = h1 - h0;
        va = v1 - v0;
        e.hs = (h >= hsw) ? 1 : 0;
        e.vs = (v >= vsw) ? 1 : 0;
        e.bl = (h >= h0 && h < h1 && v >= v0 && v < v1) ? 1 : 0;
        e.x  = e.bl ? h - h0 : 0;
        e.y  = e.bl ? v - v0 : 0;
        e.fs = (r == 0) ? 1 : 0;
        col  = (h < h0) ? 0 : (h >= h1) ? ha : h - h0;
        if (r == 0)       e.addr = (f > 0) ? ha * va : 0;
        else if (v < v0)  e.addr = 0;
        else if (v >= v1) e.addr = ha * va;
        else              e.addr = (v - v0) * ha + col;
        return e;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_small();
        exp_t e;
        string t;
        e = model(n_s, 40, 6, 4, 3, 20, 2, 3, 2);
        t = $sformatf("s@%0d", n_s);
        check({t, " hs"},   32'(s_if.hs),          32'(e.hs));
        check({t, " vs"},   32'(s_if.vs),          32'(e.vs));
        check({t, " bl"},   32'(s_if.blank_n),     32'(e.bl));
        check({t, " addr"}, 32'(s_if.addr),        32'(e.addr));
        check({t, " x"},    32'(s_if.x),           32'(e.x));
        check({t, " y"},    32'(s_if.y),           32'(e.y));
        check({t, " fs"},   32'(s_if.frame_start), 32'(e.fs));
    endtask

    task automatic check_full();
        exp_t e;
        string t;
        e = model(n_d, 800, 96, 48, 16, 525, 2, 33, 10);
        t = $sformatf("f@%0d", n_d);
        check({t, " hs"},   32'(d_if.hs),          32'(e.hs));
        check({t, " vs"},   32'(d_if.vs),          32'(e.vs));
        check({t, " bl"},   32'(d_if.blank_n),     32'(e.bl));
        check({t, " addr"}, 32'(d_if.addr),        32'(e.addr));
        check({t, " x"},    32'(d_if.x),           32'(e.x));
        check({t, " y"},    32'(d_if.y),           32'(e.y));
        check({t, " fs"},   32'(d_if.frame_start), 32'(e.fs));
    endtask

    initial begin
        int hold;
        repeat (3) @(negedge clk);
        check_small();
        check_full();
        rst_s = 1'b1;
        rst_d = 1'b1;
        for (int c = 0; c < 30000; c++) begin
            @(negedge clk);
            check_small();
            check_full();
            if (c > 2600 && $urandom_range(0, 299) == 0) begin
                #2 rst_s = 1'b0;
                #1 check_small();
                hold = $urandom_range(1, 5);
                repeat (hold) @(negedge clk);
                check_small();
                rst_s = 1'b1;
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
